// File: rtl/ascon_pack.sv
// ascon_pack: shared types and constants for the ASCON-128 control path.
//   type_fsm_state    - controller states
//   type_xor_down_sel - downstream XOR data select; the datapath expands it with
//                       the key into the 256-bit word XORed into state[1..4]
//   ROUNDS_A/ROUNDS_B - round counts for init/final and for AD/PT blocks
package ascon_pack;

  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    AD_WAIT = 3'd2,
    AD_PERM = 3'd3,
    PT_WAIT = 3'd4,
    PT_PERM = 3'd5,
    FINAL   = 3'd6,
    DONE    = 3'd7
  } type_fsm_state;

  typedef enum logic [1:0] {
    KEY_LO    = 2'd0,
    DS        = 2'd1,
    KEY_LO_DS = 2'd2,
    KEY_HI    = 2'd3
  } type_xor_down_sel;

endpackage

// File: rtl/ascon_round_counter.sv
// ascon_round_counter: 4-bit permutation round index.
//   clock_i, resetb_i - clock, asynchronous active-low reset (index -> 0)
//   load_i, load_val_i - load a start round (has priority over increment)
//   inc_i              - advance one round; saturates at LAST
//   round_o            - current round index
//   last_o             - round_o == LAST
module ascon_round_counter #(
  parameter int unsigned LAST = 11
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  output logic [3:0] round_o,
  output logic       last_o
);

  logic [3:0] round_q, round_d;

  assign last_o  = (round_q == 4'(LAST));
  assign round_o = round_q;

  always_comb begin
    round_d = round_q;
    if (load_i) begin
      round_d = load_val_i;
    end else if (inc_i && !last_o) begin
      round_d = round_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      round_q <= '0;
    end else begin
      round_q <= round_d;
    end
  end

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ascon_ctrl_fsm: sequencing controller for the ASCON-128 encryption datapath.
//   start_i, nb_ad_i, nb_pt_i - start request and block counts (latched on accept)
//   block_valid_i/block_ready_o - AD/PT block handshake
//   init_state_o, en_state_o, en_perm_o, round_o - state register and permutation control
//   en_xor_up_o, en_xor_down_o, sel_xor_down_o   - XOR enables and downstream data select
//   cipher_valid_o, tag_valid_o, busy_o, done_o  - status
//   dbg_state_o - current FSM state, for observation only
// Handshake: a block is transferred in a cycle where block_valid_i and block_ready_o
// are both 1. block_ready_o depends only on the registered state, never on
// block_valid_i; a producer may hold valid high and change data only after a transfer.
module ascon_ctrl_fsm #(
  parameter int CNT_W    = 8,
  parameter int ROUNDS_A = ascon_pack::ROUNDS_A,
  parameter int ROUNDS_B = ascon_pack::ROUNDS_B
) (
  input  logic                     clock_i,
  input  logic                     resetb_i,
  input  logic                     start_i,
  input  logic [CNT_W-1:0]         nb_ad_i,
  input  logic [CNT_W-1:0]         nb_pt_i,
  input  logic                     block_valid_i,
  output logic                     block_ready_o,
  output logic                     init_state_o,
  output logic                     en_state_o,
  output logic                     en_perm_o,
  output logic [3:0]               round_o,
  output logic                     en_xor_up_o,
  output logic                     en_xor_down_o,
  output logic [1:0]               sel_xor_down_o,
  output logic                     cipher_valid_o,
  output logic                     tag_valid_o,
  output logic                     busy_o,
  output logic                     done_o,
  output ascon_pack::type_fsm_state dbg_state_o
);

  import ascon_pack::*;

  // AD/PT blocks run the tail of the round schedule, ending on the same last round.
  localparam logic [3:0] RND_B_FIRST = 4'(ROUNDS_A - ROUNDS_B);

  type_fsm_state    state_q, state_d;
  type_xor_down_sel sel;
  logic [CNT_W-1:0] ad_cnt_q, ad_cnt_d;
  logic [CNT_W-1:0] pt_cnt_q, pt_cnt_d;
  logic             rc_load, rc_inc, rc_last;
  logic [3:0]       rc_val;

  ascon_round_counter #(.LAST(ROUNDS_A - 1)) u_round_counter (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .load_i     (rc_load),
    .load_val_i (rc_val),
    .inc_i      (rc_inc),
    .round_o    (round_o),
    .last_o     (rc_last)
  );

  assign sel_xor_down_o = sel;
  assign dbg_state_o    = state_q;

  always_comb begin
    state_d        = state_q;
    ad_cnt_d       = ad_cnt_q;
    pt_cnt_d       = pt_cnt_q;
    rc_load        = 1'b0;
    rc_val         = '0;
    rc_inc         = 1'b0;
    block_ready_o  = 1'b0;
    init_state_o   = 1'b0;
    en_state_o     = 1'b0;
    en_perm_o      = 1'b0;
    en_xor_up_o    = 1'b0;
    en_xor_down_o  = 1'b0;
    sel            = KEY_LO;
    cipher_valid_o = 1'b0;
    tag_valid_o    = 1'b0;
    busy_o         = 1'b1;
    done_o         = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          init_state_o = 1'b1;
          en_state_o   = 1'b1;
          ad_cnt_d     = nb_ad_i;
          // An empty message still carries one padded PT block.
          pt_cnt_d     = (nb_pt_i == '0) ? CNT_W'(1) : nb_pt_i;
          rc_load      = 1'b1;
          state_d      = INIT;
        end
      end
      INIT: begin
        en_perm_o  = 1'b1;
        en_state_o = 1'b1;
        rc_inc     = 1'b1;
        if (rc_last) begin
          en_xor_down_o = 1'b1;
          // No AD: the domain separation bit goes in together with the key.
          sel     = (ad_cnt_q == '0) ? KEY_LO_DS : KEY_LO;
          rc_load = 1'b1;
          rc_val  = RND_B_FIRST;
          state_d = (ad_cnt_q == '0) ? PT_WAIT : AD_WAIT;
        end
      end
      AD_WAIT: begin
        block_ready_o = 1'b1;
        if (block_valid_i) begin
          en_xor_up_o = 1'b1;
          en_perm_o   = 1'b1;
          en_state_o  = 1'b1;
          rc_inc      = 1'b1;
          ad_cnt_d    = ad_cnt_q - CNT_W'(1);
          state_d     = AD_PERM;
        end
      end
      AD_PERM: begin
        en_perm_o  = 1'b1;
        en_state_o = 1'b1;
        rc_inc     = 1'b1;
        if (rc_last) begin
          rc_load = 1'b1;
          rc_val  = RND_B_FIRST;
          // Counter already decremented on the handshake: zero means last block.
          if (ad_cnt_q == '0) begin
            en_xor_down_o = 1'b1;
            sel           = DS;
            state_d       = PT_WAIT;
          end else begin
            state_d = AD_WAIT;
          end
        end
      end
      PT_WAIT: begin
        block_ready_o = 1'b1;
        if (block_valid_i) begin
          en_xor_up_o    = 1'b1;
          cipher_valid_o = 1'b1;
          en_state_o     = 1'b1;
          pt_cnt_d       = pt_cnt_q - CNT_W'(1);
          if (pt_cnt_q == CNT_W'(1)) begin
            // Last block bypasses the permutation and absorbs K ahead of finalisation.
            en_xor_down_o = 1'b1;
            sel           = KEY_HI;
            rc_load       = 1'b1;
            state_d       = FINAL;
          end else begin
            en_perm_o = 1'b1;
            rc_inc    = 1'b1;
            state_d   = PT_PERM;
          end
        end
      end
      PT_PERM: begin
        en_perm_o  = 1'b1;
        en_state_o = 1'b1;
        rc_inc     = 1'b1;
        if (rc_last) begin
          rc_load = 1'b1;
          rc_val  = RND_B_FIRST;
          state_d = PT_WAIT;
        end
      end
      FINAL: begin
        en_perm_o  = 1'b1;
        en_state_o = 1'b1;
        rc_inc     = 1'b1;
        if (rc_last) begin
          en_xor_down_o = 1'b1;
          sel           = KEY_LO;
          rc_load       = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        tag_valid_o = 1'b1;
        done_o      = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q  <= IDLE;
      ad_cnt_q <= '0;
      pt_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ad_cnt_q <= ad_cnt_d;
      pt_cnt_q <= pt_cnt_d;
    end
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// tb_ascon_ctrl_fsm: randomized and directed bench for ascon_ctrl_fsm with a
// program-queue reference model and literal checks on selected cycles.
module tb_ascon_ctrl_fsm;
  import ascon_pack::*;

  localparam int CNT_W = 8;

  logic             clock_i, resetb_i, start_i, block_valid_i;
  logic [CNT_W-1:0] nb_ad_i, nb_pt_i;
  logic             block_ready_o, init_state_o, en_state_o, en_perm_o;
  logic [3:0]       round_o;
  logic             en_xor_up_o, en_xor_down_o;
  logic [1:0]       sel_xor_down_o;
  logic             cipher_valid_o, tag_valid_o, busy_o, done_o;
  type_fsm_state    dbg_state_o;

  ascon_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clock_i        (clock_i),
    .resetb_i       (resetb_i),
    .start_i        (start_i),
    .nb_ad_i        (nb_ad_i),
    .nb_pt_i        (nb_pt_i),
    .block_valid_i  (block_valid_i),
    .block_ready_o  (block_ready_o),
    .init_state_o   (init_state_o),
    .en_state_o     (en_state_o),
    .en_perm_o      (en_perm_o),
    .round_o        (round_o),
    .en_xor_up_o    (en_xor_up_o),
    .en_xor_down_o  (en_xor_down_o),
    .sel_xor_down_o (sel_xor_down_o),
    .cipher_valid_o (cipher_valid_o),
    .tag_valid_o    (tag_valid_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       ready;
    logic       init;
    logic       en_state;
    logic       en_perm;
    logic [3:0] rnd;
    logic       xor_up;
    logic       xor_down;
    logic [1:0] sel;
    logic       cipher;
    logic       tag;
    logic       busy;
    logic       done;
  } out_t;

  // One program step: 0 = fixed round cycle, 1 = wait for AD block,
  // 2 = wait for PT block, 3 = done cycle.
  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] rnd;
    logic       xd;
    logic [1:0] sel;
    logic       last;
  } item_t;

  item_t mq[$];
  out_t  trace[$];
  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0;
  logic  vrand = 1'b0;

  function automatic item_t mk(input int kind, input int rnd, input bit xd,
                               input logic [1:0] sel, input bit last);
    item_t it;
    it.kind = 2'(kind);
    it.rnd  = 4'(rnd);
    it.xd   = xd;
    it.sel  = sel;
    it.last = last;
    return it;
  endfunction

  // Expand an encryption into its cycle program from the block counts.
  function automatic void build(input int a, input int p);
    if (p == 0) p = 1;
    for (int r = 0; r < 12; r++)
      mq.push_back(mk(0, r, r == 11, (r == 11 && a == 0) ? KEY_LO_DS : KEY_LO, 1'b0));
    for (int b = 0; b < a; b++) begin
      mq.push_back(mk(1, 6, 1'b0, KEY_LO, 1'b0));
      for (int r = 7; r < 12; r++)
        mq.push_back(mk(0, r, (r == 11 && b == a - 1), (r == 11 && b == a - 1) ? DS : KEY_LO, 1'b0));
    end
    for (int b = 0; b < p - 1; b++) begin
      mq.push_back(mk(2, 6, 1'b0, KEY_LO, 1'b0));
      for (int r = 7; r < 12; r++) mq.push_back(mk(0, r, 1'b0, KEY_LO, 1'b0));
    end
    mq.push_back(mk(2, 6, 1'b0, KEY_LO, 1'b1));
    for (int r = 0; r < 12; r++) mq.push_back(mk(0, r, r == 11, KEY_LO, 1'b0));
    mq.push_back(mk(3, 0, 1'b0, KEY_LO, 1'b0));
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clock_i) begin : cmp
    out_t  e, act;
    item_t it;
    act = '{block_ready_o, init_state_o, en_state_o, en_perm_o, round_o, en_xor_up_o,
            en_xor_down_o, sel_xor_down_o, cipher_valid_o, tag_valid_o, busy_o, done_o};
    e = '0;
    if (!resetb_i) begin
      mq.delete();
    end else if (mq.size() == 0) begin
      if (start_i) begin
        e.init = 1'b1;
        e.en_state = 1'b1;
        build(int'(nb_ad_i), int'(nb_pt_i));
        trace.delete();
      end
    end else begin
      it = mq.pop_front();
      e.busy = 1'b1;
      e.rnd  = it.rnd;
      case (it.kind)
        2'd0: begin
          e.en_perm = 1'b1; e.en_state = 1'b1; e.xor_down = it.xd; e.sel = it.sel;
        end
        2'd1: begin
          e.ready = 1'b1;
          if (block_valid_i) begin
            e.xor_up = 1'b1; e.en_perm = 1'b1; e.en_state = 1'b1;
          end else mq.push_front(it);
        end
        2'd2: begin
          e.ready = 1'b1;
          if (block_valid_i) begin
            e.xor_up = 1'b1; e.cipher = 1'b1; e.en_state = 1'b1;
            if (it.last) begin
              e.xor_down = 1'b1; e.sel = KEY_HI;
            end else e.en_perm = 1'b1;
          end else mq.push_front(it);
        end
        default: begin
          e.tag = 1'b1; e.done = 1'b1;
        end
      endcase
    end
    trace.push_back(act);
    if (act.done) done_cnt++;
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL cycle_outputs t=%0t act=%h exp=%h (ready,init,st,perm,rnd,up,dn,sel,ciph,tag,busy,done)",
               $time, act, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int actual, input int expv);
    total++;
    if (actual !== expv) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, actual, expv);
    end
  endtask

  function automatic out_t tr(input int i);
    if (i < trace.size()) return trace[i];
    return '0;
  endfunction

  task automatic tick();
    @(posedge clock_i);
    #1;
    if (vrand) block_valid_i = 1'($urandom_range(0, 1));
  endtask

  task automatic start_enc(input int a, input int p);
    nb_ad_i = CNT_W'(a);
    nb_pt_i = CNT_W'(p);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < limit && done_cnt == d0; i++) tick();
    if (done_cnt == d0) chk("done_timeout", 0, 1);
  endtask

  function automatic int count_field(input int upto, input int which);
    int n;
    out_t o;
    n = 0;
    for (int i = 0; i <= upto; i++) begin
      o = tr(i);
      case (which)
        0: n += int'(o.xor_up);
        1: n += int'(o.cipher);
        2: n += int'(o.xor_down && o.sel == DS);
        default: n += int'(o.done);
      endcase
    end
    return n;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int dc;
    resetb_i = 1'b0; start_i = 1'b0; block_valid_i = 1'b0;
    nb_ad_i = '0; nb_pt_i = '0;
    repeat (3) tick();
    resetb_i = 1'b1;
    repeat (3) tick();
    chk("idle_busy", int'(busy_o), 0);
    chk("idle_round", int'(round_o), 0);

    // nb_ad=0, nb_pt=1, valid held high
    block_valid_i = 1'b1;
    start_enc(0, 1);
    wait_done(200);
    chk("t0_init_state", int'(tr(0).init), 1);
    chk("t1_round", int'(tr(1).rnd), 0);
    chk("t12_round", int'(tr(12).rnd), 11);
    chk("t12_sel_key_lo_ds", int'(tr(12).sel), int'(KEY_LO_DS));
    chk("t13_bypass", int'(tr(13).en_perm), 0);
    chk("t13_sel_key_hi", int'(tr(13).sel), int'(KEY_HI));
    chk("t13_cipher", int'(tr(13).cipher), 1);
    chk("t25_final_round", int'(tr(25).rnd), 11);
    chk("t26_done", int'(tr(26).done), 1);
    chk("t26_tag", int'(tr(26).tag), 1);
    tick();

    // nb_ad=2, nb_pt=2: 1+12+12+6+1+12+1 = 45 cycles
    start_enc(2, 2);
    wait_done(300);
    chk("ad2pt2_done_at_44", int'(tr(44).done), 1);
    chk("ad2pt2_handshakes", count_field(44, 0), 4);
    chk("ad2pt2_cipher", count_field(44, 1), 2);
    chk("ad2pt2_ds_count", count_field(44, 2), 1);
    chk("ad2pt2_ds_cycle", int'(tr(24).sel), int'(DS));
    tick();

    // Stall 5 cycles in AD_WAIT
    block_valid_i = 1'b0;
    start_enc(1, 1);
    repeat (17) tick();
    block_valid_i = 1'b1;
    wait_done(300);
    for (int i = 13; i <= 17; i++) begin
      chk("stall_ready", int'(tr(i).ready), 1);
      chk("stall_en_state", int'(tr(i).en_state), 0);
      chk("stall_round", int'(tr(i).rnd), 6);
    end
    chk("stall_done_at_37", int'(tr(37).done), 1);
    tick();

    // start pulsed during FINAL is ignored
    start_enc(0, 1);
    repeat (19) tick();
    nb_ad_i = 8'd3;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_done(200);
    dc = done_cnt;
    repeat (10) tick();
    chk("final_start_ignored_done", int'(tr(26).done), 1);
    chk("single_done", done_cnt - dc, 0);

    // nb_pt=0 behaves as nb_pt=1
    start_enc(0, 0);
    wait_done(200);
    chk("pt0_bypass", int'(tr(13).en_perm), 0);
    chk("pt0_cipher", count_field(26, 1), 1);
    chk("pt0_done_at_26", int'(tr(26).done), 1);
    tick();

    // Reset mid-INIT
    dc = done_cnt;
    start_enc(1, 1);
    repeat (4) tick();
    #2 resetb_i = 1'b0;
    #1;
    chk("rst_async_outputs", int'({block_ready_o, init_state_o, en_state_o, en_perm_o, round_o,
        en_xor_up_o, en_xor_down_o, sel_xor_down_o, cipher_valid_o, tag_valid_o, busy_o, done_o}), 0);
    repeat (3) tick();
    resetb_i = 1'b1;
    repeat (30) tick();
    chk("rst_no_done", done_cnt - dc, 0);

    // Randomized back-to-back encryptions with random valid
    vrand = 1'b1;
    for (int n = 0; n < 25; n++) begin
      start_enc(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      wait_done(2000);
      repeat ($urandom_range(0, 2)) tick();
    end
    vrand = 1'b0;
    block_valid_i = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
